seg_scan_drv: RTL and testbench

Time-multiplexed scan driver for the piano's multi-digit 7-segment display. Upstream hex-to-segment decoders each produce one 9-bit segment pattern per digit; this block takes all of them, drives one shared segment bus and a one-cold digit-select bus, and cycles through the digits. It inserts a programmable blanking gap between digits to suppress ghosting. All digit patterns are latched once per frame so the display never tears.

---
 rtl/seg_scan_drv.sv | 129 ++++++++++++
 tb/tb_seg_scan_drv.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_drv.sv
// seg_scan_drv
// Time-multiplexed scan driver for a multi-digit 7-segment display.
// All digit patterns are snapshotted once per frame, on the edge that
// lights digit 0, so a frame never shows a mix of old and new data.
// Each lit digit is preceded by a programmable blanking gap to suppress ghosting.
//
// Handshake: there is none. seg_in is a level input that is sampled only on the
// snapshot edge. en is a level enable: when it is low, the block returns to its
// reset sequence position on the next edge.
module seg_scan_drv #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DIGITS*9-1:0]   seg_in,
  output logic [8:0]            seg_out,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  frame_start
);

  // The counter must also hold BLANK_CYC itself, because the first gap after
  // reset or restart is one cycle longer (see below).
  localparam int MAXC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC + 1);
  localparam int IW   = (DIGITS < 2) ? 1 : $clog2(DIGITS);

  localparam logic [CW-1:0] SCAN_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST  = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [CW-1:0] BLANK_FIRST = CW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST    = IW'(DIGITS - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   cnt;
  // Cleared by reset and by en low. Before the first digit is shown, the
  // reset cycle itself counts toward blanking. As a result, digit 0 first
  // lights on edge BLANK_CYC+1.
  logic            armed;
  logic [8:0]      shd [DIGITS];

  logic [IW-1:0]   idx_next;
  logic [IW-1:0]   show_idx;
  logic            blank_done;
  logic            show_done;
  logic            go_show;
  logic [8:0]      shd_sel;

  // Active-low one-cold select for digit i.
  function automatic logic [DIGITS-1:0] sel_of(input logic [IW-1:0] i);
    logic [DIGITS-1:0] s;
    s = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (i == IW'(k)) s[k] = 1'b0;
    end
    return s;
  endfunction

  // Next-digit arithmetic, end-of-phase detection and shadow readout.
  always_comb begin
    idx_next   = (idx == IDX_LAST) ? '0 : idx + IW'(1);
    show_idx   = (state == ST_SHOW) ? idx_next : idx;
    blank_done = armed ? (cnt == BLANK_LAST) : (cnt == BLANK_FIRST);
    show_done  = (cnt == SCAN_LAST);
    go_show    = ((state == ST_BLANK) && blank_done) ||
                 ((state == ST_SHOW) && show_done && (BLANK_CYC == 0));
    shd_sel    = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (show_idx == IW'(k)) shd_sel = shd[k];
    end
  end

  // Scan FSM, including its registered outputs and the per-frame snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_BLANK;
      idx         <= '0;
      cnt         <= '0;
      armed       <= 1'b0;
      seg_out     <= '0;
      dig_sel     <= '1;
      frame_start <= 1'b0;
      for (int k = 0; k < DIGITS; k++) shd[k] <= '0;
    end else if (!en) begin
      // Restart position. shd is kept deliberately.
      state       <= ST_BLANK;
      idx         <= '0;
      cnt         <= '0;
      armed       <= 1'b0;
      seg_out     <= '0;
      dig_sel     <= '1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (go_show) begin
        state   <= ST_SHOW;
        armed   <= 1'b1;
        cnt     <= '0;
        idx     <= show_idx;
        dig_sel <= sel_of(show_idx);
        if (show_idx == '0) begin
          // New frame: take the snapshot. Digit 0 comes straight from
          // seg_in, because shd[0] still holds the previous frame.
          for (int k = 0; k < DIGITS; k++) shd[k] <= seg_in[9*k +: 9];
          seg_out     <= seg_in[8:0];
          frame_start <= 1'b1;
        end else begin
          seg_out <= shd_sel;
        end
      end else if ((state == ST_SHOW) && show_done) begin
        state   <= ST_BLANK;
        cnt     <= '0;
        idx     <= idx_next;
        seg_out <= '0;
        dig_sel <= '1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_drv.sv
// Bench for seg_scan_drv. Three instances cover the main configuration
// (4 digits, 4 lit, 2 blank), zero blanking (4 digits, 3 lit, 0 blank) and a
// single digit (1 digit, 2 lit, 1 blank). dut_sel chooses which instance is observed.
module tb_seg_scan_drv;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [35:0] seg_in_all;

  logic [8:0]  seg_a, seg_b, seg_c;
  logic [3:0]  dig_a, dig_b;
  logic [0:0]  dig_c;
  logic        fs_a, fs_b, fs_c;

  logic [1:0]  dut_sel;
  logic [8:0]  obs_seg;
  logic [7:0]  obs_dig;
  logic        obs_fs;

  logic [35:0] snap;
  int          n_vec;
  int          n_err;

  seg_scan_drv #(.DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(2)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .seg_in(seg_in_all),
    .seg_out(seg_a), .dig_sel(dig_a), .frame_start(fs_a));

  seg_scan_drv #(.DIGITS(4), .SCAN_DIV(3), .BLANK_CYC(0)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .seg_in(seg_in_all),
    .seg_out(seg_b), .dig_sel(dig_b), .frame_start(fs_b));

  seg_scan_drv #(.DIGITS(1), .SCAN_DIV(2), .BLANK_CYC(1)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .seg_in(seg_in_all[8:0]),
    .seg_out(seg_c), .dig_sel(dig_c), .frame_start(fs_c));

  // Clock and observation mux
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    obs_seg = '0;
    obs_dig = '1;
    obs_fs  = 1'b0;
    case (dut_sel)
      2'd0:    begin obs_seg = seg_a; obs_dig = {4'hF, dig_a};  obs_fs = fs_a; end
      2'd1:    begin obs_seg = seg_b; obs_dig = {4'hF, dig_b};  obs_fs = fs_b; end
      default: begin obs_seg = seg_c; obs_dig = {7'h7F, dig_c}; obs_fs = fs_c; end
    endcase
  end

  // Reference timing. k is the number of edges since the start, where
  // edge 1 is the first edge with reset released and en high.
  // Edges 1..b are blank, and digit 0 lights on edge b+1.
  function automatic int exp_dig(input int k, input int d, input int s, input int b);
    int u, pos;
    if (k <= b) return -1;
    u   = k - b - 1;
    pos = u % (d * (b + s));
    if ((pos % (b + s)) >= s) return -1;
    return pos / (b + s);
  endfunction

  function automatic logic exp_fs(input int k, input int d, input int s, input int b);
    if (k <= b) return 1'b0;
    return ((k - b - 1) % (d * (b + s))) == 0;
  endfunction

  // Scoreboard check
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_blank(input string tag);
    chk({tag, "_seg"}, 32'(obs_seg), 32'h0);
    chk({tag, "_dig"}, 32'(obs_dig), 32'hFF);
    chk({tag, "_fs"},  32'(obs_fs),  32'h0);
  endtask

  // Driver plus checker for edges k0..k0+n-1.
  // Mode 1: apply the tear test on instance A.
  // Mode 2: give seg_in a new random value every cycle.
  task automatic run(input int d, input int s, input int b,
                     input int k0, input int n, input int mode);
    int          dg;
    logic        fs;
    logic [7:0]  ed;
    logic [8:0]  es;
    for (int k = k0; k < k0 + n; k++) begin
      @(negedge clk);
      dg = exp_dig(k, d, s, b);
      fs = exp_fs(k, d, s, b);
      if (fs) snap = seg_in_all;
      ed = 8'hFF;
      es = 9'h0;
      if (dg >= 0) begin
        ed[dg] = 1'b0;
        es     = snap[9*dg +: 9];
      end
      chk($sformatf("k%0d_dig", k), 32'(obs_dig), 32'(ed));
      chk($sformatf("k%0d_seg", k), 32'(obs_seg), 32'(es));
      chk($sformatf("k%0d_fs",  k), 32'(obs_fs),  32'(fs));
      if (mode == 1) begin
        if (k == 3)  chk("d0_frame1",  32'(obs_seg), 32'h03f);
        if (k == 9)  chk("d1_frame1",  32'(obs_seg), 32'h006);
        if (k == 33) chk("d1_frame2",  32'(obs_seg), 32'h07d);
        if (k == 51) chk("wrap_fs",    32'(obs_fs),  32'h1);
        if (k == 4)  seg_in_all[17:9] = 9'h07d;
      end
      if (mode == 2) seg_in_all[8:0] = 9'($urandom_range(1, 511));
    end
  endtask

  // Test sequence
  initial begin
    n_vec      = 0;
    n_err      = 0;
    snap       = '0;
    dut_sel    = 2'd0;
    rst_n      = 1'b0;
    en         = 1'b1;
    seg_in_all = {9'h04f, 9'h05b, 9'h006, 9'h03f};

    // Reset is held for 5 cycles with en high and seg_in nonzero.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
        dut_sel = 2'(s);
        #1;
        chk_blank($sformatf("rst%0d_u%0d", i, s));
      end
    end
    dut_sel = 2'd0;

    // Scan order, tear-free update and wrap, through digit 2 of frame 3.
    rst_n = 1'b1;
    run(4, 4, 2, 1, 63, 1);

    // en low for 3 cycles while digit 2 is lit, then restart.
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_blank($sformatf("en_low%0d", i));
    end
    en = 1'b1;
    run(4, 4, 2, 1, 12, 0);

    // Asynchronous reset mid-SHOW: outputs blank before the next edge.
    #2 rst_n = 1'b0;
    #1 chk_blank("async_rst");
    @(negedge clk);
    chk_blank("async_hold");
    rst_n = 1'b1;
    run(4, 4, 2, 1, 10, 0);

    // Zero blanking
    dut_sel = 2'd1;
    rst_n   = 1'b0;
    @(negedge clk);
    chk_blank("b_rst");
    rst_n = 1'b1;
    run(4, 3, 0, 1, 30, 0);

    // Single digit, with fresh seg_in every cycle
    dut_sel = 2'd2;
    rst_n   = 1'b0;
    @(negedge clk);
    chk_blank("c_rst");
    rst_n = 1'b1;
    run(1, 2, 1, 1, 15, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
